// File: rtl/gear_accum_pipe.sv
// Multi-lane frame accumulator with a runtime choice of exact or GeAr(R,P) approximate addition.
// Per-lane sums, sticky overflow, GeAr-vs-exact mismatch count and beat count are presented at frame end.
module gear_accum_pipe #(
  parameter int LANES   = 4,
  parameter int WIDTH   = 16,
  parameter int R       = 4,
  parameter int P       = 4,
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_mode,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o_sum,
  output logic [LANES-1:0]       o_ovf,
  output logic [CNT_W-1:0]       o_err_cnt,
  output logic [CNT_W-1:0]       o_beat_cnt,
  output logic                   o_trunc
);

  localparam int L = R + P;
  localparam int K = (WIDTH - L) / R + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  // Handshakes: a beat transfers on a clk edge with i_valid && o_ready; a result transfers
  // on a clk edge with o_valid && i_ready. Both flags are registered, so neither side
  // sees a combinational path from the other side's valid/ready.
  state_t                 state_q;
  logic [LANES*WIDTH-1:0] sum_q;
  logic [LANES-1:0]       ovf_q;
  logic [CNT_W-1:0]       err_q, beat_q;
  logic                   trunc_q, mode_q, valid_q, ready_q;

  logic                   accept, first, mode_act, hit_max, end_frame, trunc_d;
  logic [LANES*WIDTH-1:0] sum_d;
  logic [LANES-1:0]       ovf_d;
  logic [CNT_W:0]         err_inc, err_sum;
  logic [CNT_W-1:0]       err_d, beat_d;

  // Sub-adder 0 keeps all L bits; each later window only contributes its top R bits,
  // its low P bits act as the carry predictor.
  function automatic logic [WIDTH-1:0] gear_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    logic [L:0]       part;
    g    = '0;
    part = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]};
    g[L-1:0] = part[L-1:0];
    for (int i = 1; i < K; i++) begin
      part = {1'b0, a[i*R +: L]} + {1'b0, b[i*R +: L]};
      g[i*R+P +: R] = part[P +: R];
    end
    return g;
  endfunction

  assign accept   = i_valid && ready_q;
  assign first    = (state_q == S_IDLE);
  assign mode_act = first ? i_mode : mode_q;

  always_comb begin
    logic [WIDTH-1:0] a, b, e, g, r;
    sum_d   = '0;
    ovf_d   = ovf_q;
    err_inc = '0;
    a = '0; b = '0; e = '0; g = '0; r = '0;
    for (int n = 0; n < LANES; n++) begin
      a = first ? '0 : sum_q[n*WIDTH +: WIDTH];
      b = i_data[n*WIDTH +: WIDTH];
      e = a + b;
      g = gear_add(a, b);
      r = mode_act ? g : e;
      sum_d[n*WIDTH +: WIDTH] = r;
      if ((a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1])) ovf_d[n] = 1'b1;
      if (mode_act && (g != e)) err_inc = err_inc + (CNT_W+1)'(1);
    end
    err_sum   = {1'b0, err_q} + err_inc;
    err_d     = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    beat_d    = beat_q + CNT_W'(1);
    hit_max   = (beat_d == CNT_W'(MAX_LEN));
    end_frame = i_last || hit_max;
    trunc_d   = hit_max && !i_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      ovf_q   <= '0;
      err_q   <= '0;
      beat_q  <= '0;
      trunc_q <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            sum_q  <= sum_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            beat_q <= beat_d;
            if (first) mode_q <= i_mode;
            if (end_frame) begin
              trunc_q <= trunc_d;
              state_q <= S_HOLD;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (i_ready) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            ovf_q   <= '0;
            err_q   <= '0;
            beat_q  <= '0;
            trunc_q <= 1'b0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_sum      = sum_q;
  assign o_ovf      = ovf_q;
  assign o_err_cnt  = err_q;
  assign o_beat_cnt = beat_q;
  assign o_trunc    = trunc_q;

endmodule

// File: tb/tb_gear_accum_pipe.sv
// Bench for gear_accum_pipe: hand vectors, corner sequences and random frames against an arithmetic model.
module tb_gear_accum_pipe;
  localparam int LANES = 4, WIDTH = 16, CNT_W = 8, MAX_LEN = 255, DW = LANES * WIDTH;

  logic          clk = 1'b0, rst = 1'b1;
  logic          i_mode = 1'b0, i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready, o_valid, o_trunc;
  logic [DW-1:0] o_sum;
  logic [LANES-1:0] o_ovf;
  logic [CNT_W-1:0] o_err_cnt, o_beat_cnt;

  gear_accum_pipe #(.LANES(LANES), .WIDTH(WIDTH), .R(4), .P(4), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_ovf(o_ovf), .o_err_cnt(o_err_cnt), .o_beat_cnt(o_beat_cnt), .o_trunc(o_trunc)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0]    sum;
    logic [LANES-1:0] ovf;
    logic [CNT_W-1:0] err;
    logic [CNT_W-1:0] beats;
    logic             trunc;
  } res_t;
  localparam int RW = $bits(res_t);
  logic [RW-1:0] exp_q[$];

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] frame_data [0:299];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_acc [LANES];
  logic [LANES-1:0] m_ovf;
  int m_err, m_beats;
  logic m_mode;

  task automatic m_clear();
    for (int n = 0; n < LANES; n++) m_acc[n] = '0;
    m_ovf = '0; m_err = 0; m_beats = 0; m_mode = 1'b0;
  endtask

  function automatic logic [15:0] m_gear(input logic [15:0] a, input logic [15:0] b);
    int g, blk;
    g = (int'(a[7:0]) + int'(b[7:0])) % 256;
    for (int s = 4; s + 8 <= 16; s += 4) begin
      blk = ((((int'(a) >> s) % 256) + ((int'(b) >> s) % 256)) / 16) % 16;
      g = g + (blk << (s + 4));
    end
    return 16'(g);
  endfunction

  task automatic m_beat(input logic [DW-1:0] d, input logic mode_in);
    logic [15:0] a, b, e, g, r;
    if (m_beats == 0) m_mode = mode_in;
    for (int n = 0; n < LANES; n++) begin
      a = (m_beats == 0) ? 16'h0 : m_acc[n];
      b = d[n*WIDTH +: WIDTH];
      e = 16'((int'(a) + int'(b)) % 65536);
      g = m_gear(a, b);
      r = m_mode ? g : e;
      if (a[15] == b[15] && r[15] != a[15]) m_ovf[n] = 1'b1;
      if (m_mode && g != e) m_err++;
      m_acc[n] = r;
    end
    if (m_err > 255) m_err = 255;
    m_beats++;
  endtask

  function automatic res_t m_result(input logic last);
    res_t r;
    r.sum   = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
    r.ovf   = m_ovf;
    r.err   = 8'(m_err);
    r.beats = 8'(m_beats);
    r.trunc = (m_beats == MAX_LEN) && !last;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic drive_beat(input logic [DW-1:0] d, input logic last, input logic mode);
    int guard = 0;
    i_valid = 1'b1; i_data = d; i_last = last; i_mode = mode;
    while (!o_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!o_ready) chk("beat_accept_timeout", 64'(o_ready), 64'(1));
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic run_frame(input int n, input logic mode0, input logic toggle, input logic use_last);
    logic md;
    m_clear();
    for (int i = 0; i < n; i++) begin
      md = toggle ? (mode0 ^ logic'(i % 2)) : mode0;
      drive_beat(frame_data[i], use_last && (i == n - 1), md);
      m_beat(frame_data[i], md);
    end
  endtask

  task automatic check_result(input int hold_cycles);
    res_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'(0), 64'(1));
      return;
    end
    e = res_t'(exp_q.pop_front());
    chk("latency_valid", 64'(o_valid), 64'(1));
    chk("ready_in_hold", 64'(o_ready), 64'(0));
    chk("sum", o_sum, e.sum);
    chk("ovf", 64'(o_ovf), 64'(e.ovf));
    chk("err_cnt", 64'(o_err_cnt), 64'(e.err));
    chk("beat_cnt", 64'(o_beat_cnt), 64'(e.beats));
    chk("trunc", 64'(o_trunc), 64'(e.trunc));
    for (int c = 0; c < hold_cycles; c++) begin
      i_valid = 1'b1; i_data = {$urandom, $urandom}; i_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_valid", 64'(o_valid), 64'(1));
      chk("hold_ready", 64'(o_ready), 64'(0));
      chk("hold_sum", o_sum, e.sum);
      chk("hold_beats", 64'(o_beat_cnt), 64'(e.beats));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("release_ready", 64'(o_ready), 64'(1));
    chk("release_valid", 64'(o_valid), 64'(0));
    chk("release_beats", 64'(o_beat_cnt), 64'(0));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_ready"}, 64'(o_ready), 64'(1));
    chk({tag, "_sum"}, o_sum, 64'(0));
    chk({tag, "_ovf"}, 64'(o_ovf), 64'(0));
    chk({tag, "_err"}, 64'(o_err_cnt), 64'(0));
    chk({tag, "_beats"}, 64'(o_beat_cnt), 64'(0));
    chk({tag, "_trunc"}, 64'(o_trunc), 64'(0));
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        mode;
    int          n;
    logic [15:0] b0, b1;
    logic [15:0] s0;
    logic        ovf0;
    logic [7:0]  err;
    int          hold;
  } vec_t;
  vec_t tbl [8];

  initial begin
    res_t r;
    tbl[0] = '{1'b0, 1, 16'h0005, 16'h0000, 16'h0005, 1'b0, 8'd0, 0};
    tbl[1] = '{1'b0, 1, 16'h000A, 16'h0000, 16'h000A, 1'b0, 8'd0, 0};
    tbl[2] = '{1'b0, 2, 16'h0005, 16'h000A, 16'h000F, 1'b0, 8'd0, 0};
    tbl[3] = '{1'b1, 2, 16'h00FF, 16'h0001, 16'h0000, 1'b0, 8'd1, 0};
    tbl[4] = '{1'b0, 2, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 8'd0, 0};
    tbl[5] = '{1'b0, 2, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 8'd0, 5};
    tbl[6] = '{1'b1, 2, 16'h7FFF, 16'h0001, 16'h7F00, 1'b0, 8'd1, 0};
    tbl[7] = '{1'b0, 1, 16'h0003, 16'h0000, 16'h0003, 1'b0, 8'd0, 0};

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle_zero("reset");

    // hand vectors; vector 5 also holds i_ready low for 5 cycles with stray beats
    for (int v = 0; v < 8; v++) begin
      frame_data[0] = {48'h0, tbl[v].b0};
      frame_data[1] = {48'h0, tbl[v].b1};
      run_frame(tbl[v].n, tbl[v].mode, 1'b0, 1'b1);
      r = '{sum: {48'h0, tbl[v].s0}, ovf: {3'b0, tbl[v].ovf0}, err: tbl[v].err,
            beats: 8'(tbl[v].n), trunc: 1'b0};
      exp_q.push_back(r);
      check_result(tbl[v].hold);
    end

    // truncation at MAX_LEN without i_last, then with i_last on the final beat
    for (int i = 0; i < MAX_LEN; i++) frame_data[i] = 64'h0001_0001_0001_0001;
    run_frame(MAX_LEN, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(res_t'{sum: 64'h00FF_00FF_00FF_00FF, ovf: 4'h0, err: 8'd0, beats: 8'd255, trunc: 1'b1});
    check_result(0);
    run_frame(MAX_LEN, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(res_t'{sum: 64'h00FF_00FF_00FF_00FF, ovf: 4'h0, err: 8'd0, beats: 8'd255, trunc: 1'b0});
    check_result(0);

    // reset in the middle of a frame discards it
    for (int i = 0; i < 3; i++) frame_data[i] = 64'h1234_8000_7FFF_00FF;
    run_frame(3, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_zero("midreset");
    frame_data[0] = 64'h0000_0000_0000_0002;
    run_frame(1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(res_t'{sum: 64'h2, ovf: 4'h0, err: 8'd0, beats: 8'd1, trunc: 1'b0});
    check_result(0);

    // i_mode toggled mid-frame: first-beat mode wins
    frame_data[0] = 64'h00FF; frame_data[1] = 64'h0001;
    run_frame(2, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(res_t'{sum: 64'h0000, ovf: 4'h0, err: 8'd1, beats: 8'd2, trunc: 1'b0});
    check_result(0);
    run_frame(2, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(res_t'{sum: 64'h0100, ovf: 4'h0, err: 8'd0, beats: 8'd2, trunc: 1'b0});
    check_result(0);

    // random frames against the model
    for (int f = 0; f < 40; f++) begin
      int n;
      logic md, tg;
      n  = $urandom_range(1, 12);
      md = 1'($urandom_range(0, 1));
      tg = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) frame_data[i] = {$urandom, $urandom};
      run_frame(n, md, tg, 1'b1);
      exp_q.push_back(m_result(1'b1));
      check_result($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
